ps2_frame_rx: RTL and testbench

PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_line_filter.sv | 41 ++++
 rtl/ps2_frame_rx.sv | 135 +++++++++++++
 tb/tb_ps2_frame_rx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 frame receiver: FSM states,
// well-known scan codes and default timing parameters.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

    typedef enum logic [7:0] {
        SC_EXTENDED = 8'hE0,
        SC_BREAK    = 8'hF0
    } ps2_scan_code_t;

    localparam int unsigned DEFAULT_FILTER_LEN    = 4;
    localparam int unsigned DEFAULT_TIMEOUT_TICKS = 600;

    // PS/2 uses odd parity over the eight data bits plus the parity bit.
    function automatic logic odd_ones(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a level filter: the output level only
// moves after FILTER_LEN consecutive equal samples (FILTER_LEN >= 2).
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk_2,
    input  logic rst_n,
    input  logic i_line,
    output logic o_level
);

    logic                  r_sync1;
    logic                  r_sync2;
    logic [FILTER_LEN-2:0] r_hist;
    logic                  r_level;
    logic [FILTER_LEN-1:0] w_window;

    // The newest synchronized sample plus the FILTER_LEN-1 before it.
    assign w_window = {r_hist, r_sync2};
    assign o_level  = r_level;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk_2) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= '1;
            r_level <= 1'b1;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
            r_hist  <= w_window[FILTER_LEN-2:0];
            if (&w_window) begin
                r_level <= 1'b1;
            end else if (~|w_window) begin
                r_level <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver with inactivity watchdog.
// Define PS2_RX_PARITY_EN to reject frames whose parity bit is wrong.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN    = DEFAULT_FILTER_LEN,
    parameter int unsigned TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS
) (
    input  logic       clk_2,
    input  logic       rst_n,
    input  logic       clk_300k,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] check_code,
    output logic       code_new_updated,
    output logic       frame_err
);

`ifdef PS2_RX_PARITY_EN
    localparam bit PARITY_CHECK = 1'b1;
`else
    localparam bit PARITY_CHECK = 1'b0;
`endif
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_TICKS + 1);

    logic              w_clk_f;
    logic              w_data_f;
    logic              w_fall;
    logic              w_frame_ok;
    logic              w_timeout;
    logic              w_emit_code;
    logic              w_emit_err;
    ps2_state_t        r_state;
    ps2_state_t        w_state_next;
    logic              r_clk_prev;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_parity;
    logic [WDOG_W-1:0] r_wdog;
    logic [7:0]        r_check_code;
    logic              r_code_new;
    logic              r_frame_err;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk_2   (clk_2),
        .rst_n   (rst_n),
        .i_line  (ps2_clk),
        .o_level (w_clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk_2   (clk_2),
        .rst_n   (rst_n),
        .i_line  (ps2_data),
        .o_level (w_data_f)
    );

    assign w_fall     = r_clk_prev & ~w_clk_f;
    assign w_frame_ok = w_data_f && (!PARITY_CHECK || odd_ones({r_shift, r_parity}));
    // An edge in the same cycle as a strobe restarts the watchdog instead of expiring it.
    assign w_timeout  = (r_state != ST_IDLE) && !w_fall && clk_300k &&
                        (r_wdog == WDOG_W'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clk_2) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_emit_code  = 1'b0;
        w_emit_err   = 1'b0;
        if (w_timeout) begin
            w_state_next = ST_IDLE;
            w_emit_err   = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE:   if (!w_data_f) w_state_next = ST_DATA;
                ST_DATA:   if (r_bit_cnt == 3'd7) w_state_next = ST_PARITY;
                ST_PARITY: w_state_next = ST_STOP;
                ST_STOP: begin
                    w_state_next = ST_IDLE;
                    w_emit_code  = w_frame_ok;
                    w_emit_err   = !w_frame_ok;
                end
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_2) begin
        if (!rst_n) begin
            r_clk_prev   <= 1'b1;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_parity     <= 1'b0;
            r_wdog       <= '0;
            r_check_code <= 8'h00;
            r_code_new   <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_clk_prev <= w_clk_f;
            if (w_fall) begin
                case (r_state)
                    ST_IDLE:   r_bit_cnt <= 3'd0;
                    ST_DATA: begin
                        r_shift   <= {w_data_f, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    ST_PARITY: r_parity <= w_data_f;
                    default:   ;
                endcase
            end
            if (r_state == ST_IDLE || w_fall || w_timeout) begin
                r_wdog <= '0;
            end else if (clk_300k) begin
                r_wdog <= r_wdog + WDOG_W'(1);
            end
            r_code_new  <= w_emit_code;
            r_frame_err <= w_emit_err;
            if (w_emit_code) begin
                r_check_code <= r_shift;
            end
        end
    end

    assign check_code       = r_check_code;
    assign code_new_updated = r_code_new;
    assign frame_err        = r_frame_err;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Self-checking bench for ps2_frame_rx: directed corner cases plus random
// frames scored against a frame-level model of the PS/2 protocol rules.
module tb_ps2_frame_rx;
    import ps2_pkg::*;

    localparam int FILTER_LEN    = 4;
    localparam int TIMEOUT_TICKS = 600;
    localparam int HALF          = 35;
    // Raw edge -> two sync flops -> FILTER_LEN equal samples -> registered pulse.
    localparam int LAT           = 3 + FILTER_LEN;
`ifdef PS2_RX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    logic       clk_2    = 1'b0;
    logic       rst_n    = 1'b0;
    logic       clk_300k = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] check_code;
    logic       code_new_updated;
    logic       frame_err;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         cyc_cnt  = 0;
    int         n_code   = 0;
    int         n_err    = 0;
    int         last_code_cyc = -1;
    int         last_err_cyc  = -1;
    int         fall_cyc = 0;
    logic [7:0] last_code_val = 8'h00;
    logic       prev_code = 1'b0;
    logic       prev_err  = 1'b0;
    bit         strobe_on = 1'b1;
    logic [7:0] exp_code  = 8'h00;

    always #5 clk_2 = ~clk_2;

    ps2_frame_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_TICKS(TIMEOUT_TICKS)) dut (
        .clk_2            (clk_2),
        .rst_n            (rst_n),
        .clk_300k         (clk_300k),
        .ps2_clk          (ps2_clk),
        .ps2_data         (ps2_data),
        .check_code       (check_code),
        .code_new_updated (code_new_updated),
        .frame_err        (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clk_2 cycle; outputs are inspected 1 ns after the rising edge.
    task automatic cyc();
        clk_300k = strobe_on;
        @(posedge clk_2);
        #1;
        cyc_cnt++;
        if (code_new_updated === 1'b1) begin
            n_code++;
            last_code_cyc = cyc_cnt;
            last_code_val = check_code;
            check("code_pulse_width", 32'(prev_code), 32'd0);
            check("pulse_exclusive", 32'(frame_err), 32'd0);
        end
        if (frame_err === 1'b1) begin
            n_err++;
            last_err_cyc = cyc_cnt;
            check("err_pulse_width", 32'(prev_err), 32'd0);
        end
        prev_code = code_new_updated;
        prev_err  = frame_err;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) cyc();
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cycles(HALF);
        ps2_clk  = 1'b0;
        fall_cyc = cyc_cnt;
        wait_cycles(HALF);
        ps2_clk  = 1'b1;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic par, input logic stop);
        return {stop, par, d, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int glitch_at);
        logic [10:0] f;
        f = frame_bits(d, par, stop);
        for (int i = 0; i < 11; i++) begin
            if (i == glitch_at) begin
                wait_cycles(5);
                ps2_clk = 1'b0;
                wait_cycles(2);
                ps2_clk = 1'b1;
            end
            send_bit(f[i]);
        end
        ps2_data = 1'b1;
    endtask

    // Frame-level reference: valid iff stop=1 and, when enabled, odd parity.
    task automatic do_frame(input string tag, input logic [7:0] d, input logic par,
                            input logic stop, input int glitch_at);
        int c0;
        int e0;
        bit valid;
        c0 = n_code;
        e0 = n_err;
        send_frame(d, par, stop, glitch_at);
        valid = stop && (!PARITY_EN || ((^d) ^ par));
        if (valid) exp_code = d;
        check({tag, "_code_pulses"}, 32'(n_code - c0), 32'(valid));
        check({tag, "_err_pulses"}, 32'(n_err - e0), 32'(!valid));
        check({tag, "_check_code"}, 32'(check_code), 32'(exp_code));
        if (valid) begin
            check({tag, "_code_latency"}, 32'(last_code_cyc), 32'(fall_cyc + LAT));
            check({tag, "_code_value"}, 32'(last_code_val), 32'(d));
        end else begin
            check({tag, "_err_latency"}, 32'(last_err_cyc), 32'(fall_cyc + LAT));
        end
    endtask

    initial begin
        int c0;
        int e0;
        int err_strobe;
        logic [10:0] f;
        logic [7:0] d;
        logic par;
        logic stop;

        // Reset state.
        wait_cycles(4);
        check("rst_check_code", 32'(check_code), 32'h00);
        check("rst_code_new", 32'(code_new_updated), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        wait_cycles(20);

        // A falling edge with data high in idle is not a start bit.
        c0 = n_code;
        e0 = n_err;
        send_bit(1'b1);
        wait_cycles(20);
        check("stray_edge_pulses", 32'(n_code - c0 + n_err - e0), 32'd0);

        do_frame("f77", 8'h77, 1'b1, 1'b1, -1);
        wait_cycles(2);
        do_frame("b2b_77", 8'h77, 1'b1, 1'b1, -1);
        do_frame("b2b_f0", SC_BREAK, 1'b1, 1'b1, -1);
        wait_cycles(10);
        do_frame("bad_par", 8'h77, 1'b0, 1'b1, -1);
        wait_cycles(10);
        do_frame("bad_stop", 8'h1C, 1'b0, 1'b0, -1);
        wait_cycles(10);

        // Watchdog: five bits, then strobes with the bus stalled.
        strobe_on = 1'b0;
        c0 = n_code;
        e0 = n_err;
        f = frame_bits(8'hA5, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) send_bit(f[i]);
        ps2_data = 1'b1;
        wait_cycles(10);
        err_strobe = -1;
        for (int k = 1; k <= 700; k++) begin
            strobe_on = 1'b1;
            cyc();
            strobe_on = 1'b0;
            cyc();
            if (n_err != e0 && err_strobe < 0) err_strobe = k;
        end
        check("timeout_strobe", 32'(err_strobe), 32'(TIMEOUT_TICKS));
        check("timeout_err_pulses", 32'(n_err - e0), 32'd1);
        check("timeout_code_pulses", 32'(n_code - c0), 32'd0);
        check("timeout_check_code", 32'(check_code), 32'(exp_code));
        strobe_on = 1'b1;
        do_frame("after_timeout", 8'h1C, 1'b0, 1'b1, -1);
        wait_cycles(10);

        // Random frames against the reference model.
        for (int i = 0; i < 24; i++) begin
            d    = 8'($urandom_range(0, 255));
            par  = ($urandom_range(0, 3) == 0) ? (^d) : ~(^d);
            stop = ($urandom_range(0, 7) != 0);
            do_frame("rand", d, par, stop, -1);
            wait_cycles($urandom_range(2, 40));
        end

        // A two-cycle low glitch on ps2_clk must not shift a bit.
        do_frame("glitch", 8'h5A, 1'b1, 1'b1, 5);
        wait_cycles(10);

        // Reset during bit 3 discards the partial frame.
        c0 = n_code;
        e0 = n_err;
        f = frame_bits(8'h3C, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(f[i]);
        ps2_data = f[4];
        wait_cycles(HALF);
        ps2_clk = 1'b0;
        wait_cycles(3);
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cycles(10);
        exp_code = 8'h00;
        check("midrst_check_code", 32'(check_code), 32'h00);
        check("midrst_code_new", 32'(code_new_updated), 32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        wait_cycles(40);
        check("midrst_pulses", 32'(n_code - c0 + n_err - e0), 32'd0);
        do_frame("after_reset", 8'h77, 1'b1, 1'b1, -1);
        wait_cycles(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
